// File: rtl/booth_mul_pkg.sv
// Shared types for the radix-4 Booth sequential multiplier: FSM states,
// recoded digit values and the internal operand-width helper.
package booth_mul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  typedef enum logic [2:0] {
    ZERO,
    POS1,
    POS2,
    NEG2,
    NEG1
  } digit_e;

  // Smallest even width holding W bits plus one spare sign bit, so an
  // unsigned operand never produces a negative top digit.
  function automatic int calc_n(input int w);
    return 2 * ((w + 2) / 2);
  endfunction

endpackage

// File: rtl/booth_r4_digit.sv
// Radix-4 Booth recoder: maps a multiplier triplet onto a signed partial
// product (0, +-X, +-2X) of width N+2.
module booth_r4_digit
  import booth_mul_pkg::*;
#(
  parameter int N = 10
) (
  input  logic [2:0]   trip_i,
  input  logic [N-1:0] x_i,
  output logic [N+1:0] pp_o
);

  digit_e       digit;
  logic [N+1:0] x1;
  logic [N+1:0] x2;
  logic [N+1:0] mag;

  assign x1 = {{2{x_i[N-1]}}, x_i};
  assign x2 = {x_i[N-1], x_i, 1'b0};

  always_comb begin
    digit = ZERO;
    case (trip_i)
      3'b000, 3'b111: digit = ZERO;
      3'b001, 3'b010: digit = POS1;
      3'b011:         digit = POS2;
      3'b100:         digit = NEG2;
      default:        digit = NEG1;
    endcase
  end

  always_comb begin
    mag = '0;
    case (digit)
      POS1, NEG1: mag = x1;
      POS2, NEG2: mag = x2;
      default:    mag = '0;
    endcase
    if (digit == NEG1 || digit == NEG2) begin
      pp_o = ~mag + (N + 2)'(1);
    end else begin
      pp_o = mag;
    end
  end

endmodule

// File: rtl/booth_r4_seq_mul.sv
// Sequential radix-4 Booth multiplier retiring two multiplier bits per cycle,
// signed or unsigned per operation, with start/busy/done and a held product.
module booth_r4_seq_mul
  import booth_mul_pkg::*;
#(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sgn,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic             busy,
  output logic             done,
  output logic [2*W-1:0]   product
);

  localparam int N     = calc_n(W);
  localparam int STEPS = N / 2;
  localparam int CW    = $clog2(STEPS);

  state_e         state_q, state_d;
  logic [N+1:0]   acc_q, acc_d;
  logic [N-1:0]   mq_q, mq_d;
  logic [N-1:0]   x_q, x_d;
  logic           qm1_q, qm1_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] prod_q, prod_d;

  logic [N-1:0]   a_ext, b_ext;
  logic [N+1:0]   pp, sum, acc_sh;
  logic [N-1:0]   mq_sh;
  logic [2*W-1:0] prod_next;
  logic           accept, last;

  assign a_ext = sgn ? {{(N-W){a[W-1]}}, a} : {{(N-W){1'b0}}, a};
  assign b_ext = sgn ? {{(N-W){b[W-1]}}, b} : {{(N-W){1'b0}}, b};

  booth_r4_digit #(.N(N)) u_digit (
    .trip_i ({mq_q[1:0], qm1_q}),
    .x_i    (x_q),
    .pp_o   (pp)
  );

  // Add the partial product, then shift {A,Q,q(-1)} right by two.
  assign sum       = acc_q + pp;
  assign acc_sh    = {{2{sum[N+1]}}, sum[N+1:2]};
  assign mq_sh     = {sum[1:0], mq_q[N-1:2]};
  assign prod_next = (2 * W)'({acc_sh, mq_sh});

  assign last   = (cnt_q == CW'(STEPS - 1));
  assign accept = start && (state_q != RUN);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    x_d     = x_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        acc_d = acc_sh;
        mq_d  = mq_sh;
        qm1_d = mq_q[1];
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          state_d = DONE;
          prod_d  = prod_next;
        end
      end
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) begin
      acc_d = '0;
      mq_d  = b_ext;
      x_d   = a_ext;
      qm1_d = 1'b0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mq_q    <= '0;
      x_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      x_q     <= x_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  // A start in the DONE cycle is accepted, so busy covers that cycle too.
  assign busy    = (state_q == RUN) || (state_q == DONE && start);
  assign done    = (state_q == DONE);
  assign product = prod_q;

endmodule

// File: tb/tb_booth_r4_seq_mul.sv
// Directed bench for booth_r4_seq_mul: W=8 hand-computed vectors, handshake
// corner cases, mid-operation reset, and a W=7 sweep against a plain multiply.
module tb_booth_r4_seq_mul;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        s8_start, s8_sgn, s8_busy, s8_done;
  logic [7:0]  s8_a, s8_b;
  logic [15:0] s8_prod;

  logic        s7_start, s7_sgn, s7_busy, s7_done;
  logic [6:0]  s7_a, s7_b;
  logic [13:0] s7_prod;

  int n_assert = 0;
  int n_fail   = 0;

  logic [6:0] rx, ry;
  bit         rs;
  bit         seen_done;

  booth_r4_seq_mul #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .start(s8_start), .sgn(s8_sgn), .a(s8_a), .b(s8_b),
    .busy(s8_busy), .done(s8_done), .product(s8_prod)
  );

  booth_r4_seq_mul #(.W(7)) dut7 (
    .clk(clk), .rst(rst), .start(s7_start), .sgn(s7_sgn), .a(s7_a), .b(s7_b),
    .busy(s7_busy), .done(s7_done), .product(s7_prod)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] ref7(input bit sg, input logic [6:0] x, input logic [6:0] y);
    logic signed [13:0] sx, sy;
    if (sg) begin
      sx = {{7{x[6]}}, x};
      sy = {{7{y[6]}}, y};
      return sx * sy;
    end
    return {7'b0, x} * {7'b0, y};
  endfunction

  // One complete operation on the selected instance with latency and pulse checks.
  task automatic op(input bit w7, input bit sg, input logic [7:0] av, input logic [7:0] bv,
                    input logic [15:0] exp, input int lat, input string tag);
    int cyc;
    bit got;
    if (w7) begin
      s7_start = 1'b1; s7_sgn = sg; s7_a = av[6:0]; s7_b = bv[6:0];
    end else begin
      s8_start = 1'b1; s8_sgn = sg; s8_a = av; s8_b = bv;
    end
    tick;
    s7_start = 1'b0;
    s8_start = 1'b0;
    check({tag, " busy_after_start"}, w7 ? s7_busy : s8_busy, 32'd1);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 20) begin
      tick;
      cyc++;
      got = w7 ? s7_done : s8_done;
    end
    check({tag, " latency"}, cyc, lat);
    check({tag, " product"}, w7 ? {2'b0, s7_prod} : s8_prod, exp);
    check({tag, " busy_at_done"}, w7 ? s7_busy : s8_busy, 32'd0);
    tick;
    check({tag, " done_pulse"}, w7 ? s7_done : s8_done, 32'd0);
    check({tag, " product_held"}, w7 ? {2'b0, s7_prod} : s8_prod, exp);
  endtask

  initial begin
    rst = 1'b0;
    s8_start = 1'b0; s8_sgn = 1'b0; s8_a = '0; s8_b = '0;
    s7_start = 1'b0; s7_sgn = 1'b0; s7_a = '0; s7_b = '0;
    #2 rst = 1'b1;
    tick;
    check("reset busy", s8_busy, 32'd0);
    check("reset done", s8_done, 32'd0);
    check("reset product", s8_prod, 32'd0);
    check("reset w7 product", s7_prod, 32'd0);
    rst = 1'b0;
    tick;

    op(1'b0, 1'b1, 8'h80, 8'h80, 16'h4000, 5, "s_min_min");
    op(1'b0, 1'b0, 8'hFF, 8'hFF, 16'hFE01, 5, "u_max_max");
    op(1'b0, 1'b1, 8'hFF, 8'hFF, 16'h0001, 5, "s_m1_m1");
    op(1'b0, 1'b1, 8'h7F, 8'h80, 16'hC080, 5, "s_max_min");
    op(1'b0, 1'b1, 8'hFF, 8'h01, 16'hFFFF, 5, "s_m1_p1");

    // start held high through RUN must be ignored
    s8_start = 1'b1; s8_sgn = 1'b0; s8_a = 8'd3; s8_b = 8'd5;
    tick;
    for (int i = 0; i < 4; i++) begin
      s8_a = 8'($urandom_range(0, 255));
      s8_b = 8'($urandom_range(0, 255));
      s8_sgn = 1'($urandom_range(0, 1));
      s8_start = 1'b1;
      tick;
      check("ignore no_done", s8_done, 32'd0);
      check("ignore busy", s8_busy, 32'd1);
    end
    s8_start = 1'b0;
    tick;
    check("ignore done", s8_done, 32'd1);
    check("ignore product", s8_prod, 32'h000F);
    tick;
    check("ignore single_done", s8_done, 32'd0);
    check("ignore idle_busy", s8_busy, 32'd0);

    // back-to-back accept in the DONE cycle
    s8_start = 1'b1; s8_sgn = 1'b0; s8_a = 8'd10; s8_b = 8'd20;
    tick;
    s8_start = 1'b0;
    repeat (5) tick;
    check("b2b first done", s8_done, 32'd1);
    check("b2b first product", s8_prod, 32'h00C8);
    s8_start = 1'b1; s8_sgn = 1'b1; s8_a = 8'hFD; s8_b = 8'd7;
    #1;
    check("b2b busy_in_done", s8_busy, 32'd1);
    tick;
    s8_start = 1'b0;
    check("b2b busy_after_load", s8_busy, 32'd1);
    check("b2b no_done", s8_done, 32'd0);
    check("b2b product_held", s8_prod, 32'h00C8);
    for (int i = 0; i < 4; i++) begin
      tick;
      check("b2b busy_run", s8_busy, 32'd1);
    end
    tick;
    check("b2b second done", s8_done, 32'd1);
    check("b2b second product", s8_prod, 32'hFFEB);
    tick;

    // asynchronous reset two cycles into an operation
    s8_start = 1'b1; s8_sgn = 1'b0; s8_a = 8'd50; s8_b = 8'd60;
    tick;
    s8_start = 1'b0;
    tick;
    tick;
    rst = 1'b1;
    #1;
    check("midrst busy", s8_busy, 32'd0);
    check("midrst done", s8_done, 32'd0);
    check("midrst product", s8_prod, 32'd0);
    tick;
    rst = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (s8_done) seen_done = 1'b1;
    end
    check("midrst no_done_after", seen_done, 32'd0);
    op(1'b0, 1'b1, 8'd12, 8'hF5, 16'hFF7C, 5, "after_rst");

    // W=7 build: corners then random operands in both modes
    op(1'b1, 1'b1, 8'h40, 8'h40, 16'h1000, 4, "w7_s_min_min");
    op(1'b1, 1'b0, 8'h7F, 8'h7F, 16'h3F01, 4, "w7_u_max_max");
    for (int i = 0; i < 200; i++) begin
      rs = 1'($urandom_range(0, 1));
      rx = 7'($urandom_range(0, 127));
      ry = 7'($urandom_range(0, 127));
      op(1'b1, rs, {1'b0, rx}, {1'b0, ry}, {2'b0, ref7(rs, rx, ry)}, 4, "w7_rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
